fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 4, is the number of fetched-instruction buffer entries, a power of two and at least 2.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  is the hazard hold; when high, the IF/ID outputs hold their values.
REQ-006 branchTaken  input  1  requests a redirect of fetch to branchTarget.
REQ-007 branchTarget  input  32  is the redirect address; bits [1:0] are ignored and treated as 0.
REQ-008 imemReady  input  1  indicates the instruction memory accepts a request this cycle.
REQ-009 imemRespValid  input  1  indicates imemRespData is valid; responses return in request order.
REQ-010 imemRespData  input  32  is the returned instruction word.
REQ-011 imemReqValid  output  1  is the fetch request strobe.
REQ-012 imemAddr  output  32  is the fetch address, always word-aligned.
REQ-013 pcOut  output  32  is the fetched address plus 4, feeding the decode stage pc input.
REQ-014 instructionOut  output  32  is the fetched word, feeding the decode stage instructionIn input.
REQ-015 validOut  output  1  marks instructionOut as a real instruction; low means bubble.

Function
REQ-016 The request is accepted when imemReqValid and imemReady are both high; on acceptance, fetchPC advances by 4, wrapping modulo 2^32.
REQ-017 imemReqValid is high when (outstanding + bufCount) < BUF_DEPTH and no branchTaken or rst is present; dequeues in the same cycle do not add credit.
REQ-018 imemAddr equals fetchPC; while imemReqValid is high and imemReady is low, imemAddr and imemReqValid hold stable.
REQ-019 outstanding increments on acceptance and decrements on imemRespValid; simultaneous events leave it unchanged.
REQ-020 Each non-discarded response is written to the buffer tail as {address+4, imemRespData}, with the address tracked per request.
REQ-021 With stall low and the buffer non-empty, the IF/ID register loads the buffer head (pcOut, instructionOut), sets validOut=1, and pops the entry.
REQ-022 With stall low and the buffer empty, the IF/ID register loads a bubble: validOut=0 and instructionOut=32'h0000_0000 (NOP); pcOut holds its value.
REQ-023 With stall high and branchTaken low, the IF/ID register, the buffer head, and validOut hold.
REQ-024 Latency: a response captured at edge E appears on the outputs after edge E+1, provided stall is low at E+1 and the buffer was empty.
REQ-025 On branchTaken, at the next edge:
- fetchPC loads {branchTarget[31:2],2'b00};
- the buffer empties;
- the IF/ID register loads a bubble;
- drop loads the outstanding count, including any request accepted in that same cycle.
REQ-026 branchTaken has priority over stall and over a simultaneous buffer write.
REQ-027 While drop is non-zero, each imemRespValid decrements drop and outstanding, and the response is discarded.
REQ-028 The buffer never overflows; a response arriving with the buffer full is a design error and is flagged by a simulation assertion.

Reset
REQ-029 On rst high at an edge:
- fetchPC = RESET_PC;
- outstanding = 0, drop = 0, buffer empty;
- pcOut = 0, instructionOut = 0, validOut = 0;
- imemReqValid is 0 during that cycle.
REQ-030 Reset overrides branchTaken and stall.
REQ-031 imemRespValid is ignored while rst is high; the instruction memory shares rst, so no stale response follows a reset.

Structure
REQ-032 Package mips_pkg holds RESET_PC default, NOP_INSTR (32'h0000_0000), and the word width constant.
REQ-033 Sub-module fetch_buffer is a synchronous FIFO of BUF_DEPTH x 64 bits with push/pop/flush/count and wrap-around pointers.

Verification
REQ-034 Reset, imemReady=1, one-cycle response latency, stall=0:
- imemAddr sequence is 0x0, 0x4, 0x8, ...;
- first validOut=1 carries pcOut=0x4 with the word for address 0x0;
- thereafter one instruction per cycle.
REQ-035 stall high for 3 cycles mid-stream:
- outputs are held unchanged;
- imemReqValid drops once outstanding + bufCount reaches 4;
- after release, the sequence resumes with no lost or duplicated pcOut.
REQ-036 branchTaken with branchTarget=0x103 while 2 requests are outstanding:
- the next imemAddr is 0x100;
- both stale responses are discarded;
- the first validOut=1 afterwards has pcOut=0x104.
REQ-037 branchTaken and stall high together:
- at the next edge, validOut=0 and instructionOut=0;
- fetch redirects.
REQ-038 imemReady low for 5 cycles: imemAddr and imemReqValid stay constant, and no address is skipped when imemReady returns high.
REQ-039 rst asserted with 3 buffered entries: the next cycle has validOut=0 and imemAddr=RESET_PC, and fetch restarts from 0x0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the fetch stage
package mips_pkg;
   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
      return {a[WORD_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO of fetched {pc+4, instruction} entries
module fetch_buffer
   import mips_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush)
         mem[wr_ptr] <= push_data;
   end

   // power-of-two depth lets the pointers wrap by plain overflow
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with credit-limited requests, redirect and IF/ID register
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic        imemReady,
   input  logic        imemRespValid,
   input  logic [31:0] imemRespData,
   output logic        imemReqValid,
   output logic [31:0] imemAddr,
   output logic [31:0] pcOut,
   output logic [31:0] instructionOut,
   output logic        validOut
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] drop;
   logic [CW-1:0] live;
   logic [CW-1:0] buf_count;
   logic [CW:0]   credit_used;
   logic          accept;
   logic          resp_fire;
   logic          resp_keep;
   logic          buf_pop;
   logic          buf_empty;
   logic          buf_full;
   fetch_entry_t  buf_in;
   fetch_entry_t  buf_head;

   // buffered entries and in-flight requests share one credit pool
   assign credit_used  = {1'b0, outstanding} + {1'b0, buf_count};
   assign imemReqValid = (credit_used < (CW+1)'(BUF_DEPTH)) && !branchTaken && !rst;
   assign imemAddr     = fetch_pc;
   assign accept       = imemReqValid && imemReady;

   assign resp_fire       = imemRespValid && !rst;
   assign resp_keep       = resp_fire && (drop == '0) && !branchTaken;
   assign outstanding_nxt = outstanding + CW'(accept) - CW'(resp_fire);

   // live requests are consecutive words ending just below fetch_pc
   assign live         = outstanding - drop;
   assign buf_in.pc    = fetch_pc - 32'({live, 2'b00}) + 32'd4;
   assign buf_in.instr = imemRespData;

   assign buf_pop = !stall && !branchTaken;

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_keep),
      .push_data (buf_in),
      .pop       (buf_pop),
      .flush     (branchTaken),
      .head      (buf_head),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= word_align(RESET_PC);
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (branchTaken) begin
            fetch_pc <= word_align(branchTarget);
            drop     <= outstanding_nxt;
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + 32'd4;
            if (resp_fire && drop != '0)
               drop <= drop - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcOut          <= '0;
         instructionOut <= '0;
         validOut       <= 1'b0;
      end else if (branchTaken) begin
         instructionOut <= NOP_INSTR;
         validOut       <= 1'b0;
      end else if (!stall) begin
         if (!buf_empty) begin
            pcOut          <= buf_head.pc;
            instructionOut <= buf_head.instr;
            validOut       <= 1'b1;
         end else begin
            instructionOut <= NOP_INSTR;
            validOut       <= 1'b0;
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(resp_keep && buf_full));
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        imemReady;
   logic        imemRespValid;
   logic [31:0] imemRespData;
   logic        imemReqValid;
   logic [31:0] imemAddr;
   logic [31:0] pcOut;
   logic [31:0] instructionOut;
   logic        validOut;

   int total = 0;
   int bad   = 0;
   int lat   = 1;
   logic [31:0] pq_addr[$];
   int          pq_age[$];

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .branchTaken    (branchTaken),
      .branchTarget   (branchTarget),
      .imemReady      (imemReady),
      .imemRespValid  (imemRespValid),
      .imemRespData   (imemRespData),
      .imemReqValid   (imemReqValid),
      .imemAddr       (imemAddr),
      .pcOut          (pcOut),
      .instructionOut (instructionOut),
      .validOut       (validOut)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   // one clock plus the in-order memory with a fixed response latency
   task automatic cycle();
      logic acc;
      logic [31:0] a;
      logic r;
      @(negedge clk);
      acc = imemReqValid && imemReady;
      a   = imemAddr;
      r   = rst;
      @(posedge clk);
      #1;
      if (imemRespValid) begin
         void'(pq_addr.pop_front());
         void'(pq_age.pop_front());
      end
      if (r) begin
         pq_addr.delete();
         pq_age.delete();
      end
      foreach (pq_age[i]) pq_age[i]++;
      if (acc) begin
         pq_addr.push_back(a);
         pq_age.push_back(0);
      end
      if (pq_age.size() > 0 && pq_age[0] >= lat - 1) begin
         imemRespValid = 1'b1;
         imemRespData  = word(pq_addr[0]);
      end else begin
         imemRespValid = 1'b0;
         imemRespData  = '0;
      end
   endtask

   task automatic do_reset(input int l);
      lat = l;
      rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0; imemReady = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h40; imemReady = 1'b1;
      cycle();
      cycle();
      total++; if (validOut !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h want=0", validOut); end
      total++; if (pcOut !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pcOut); end
      total++; if (instructionOut !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instructionOut); end
      total++; if (imemReqValid !== 1'b0) begin bad++; $display("FAIL rst_req got=%h want=0", imemReqValid); end
      rst = 1'b0; stall = 1'b0; branchTaken = 1'b0;
      #1;
      total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imemAddr); end
      total++; if (imemReqValid !== 1'b1) begin bad++; $display("FAIL rst_req_after got=%h want=1", imemReqValid); end
   endtask

   task automatic test_stream();
      do_reset(1);
      for (int i = 0; i < 10; i++) begin
         total++; if (imemAddr !== 32'(4*i)) begin bad++; $display("FAIL stream_addr%0d got=%h want=%h", i, imemAddr, 32'(4*i)); end
         cycle();
         if (i >= 2) begin
            total++; if (validOut !== 1'b1 || pcOut !== 32'(4*(i-1)) || instructionOut !== word(32'(4*(i-2)))) begin
               bad++; $display("FAIL stream_out%0d got=%h/%h/%h want=1/%h/%h", i, validOut, pcOut, instructionOut, 32'(4*(i-1)), word(32'(4*(i-2))));
            end
         end else begin
            total++; if (validOut !== 1'b0) begin bad++; $display("FAIL stream_bubble%0d got=%h want=0", i, validOut); end
         end
      end
   endtask

   task automatic test_stall();
      do_reset(1);
      repeat (5) cycle();
      stall = 1'b1;
      #1;
      for (int s = 0; s < 3; s++) begin
         total++; if (imemReqValid !== (s < 2) || (s < 2 && imemAddr !== 32'(20 + 4*s))) begin
            bad++; $display("FAIL stall_req%0d got=%h/%h want=%h/%h", s, imemReqValid, imemAddr, (s < 2), 32'(20 + 4*s));
         end
         cycle();
         total++; if (validOut !== 1'b1 || pcOut !== 32'd12 || instructionOut !== word(32'd8)) begin
            bad++; $display("FAIL stall_hold%0d got=%h/%h/%h want=1/0000000c/%h", s, validOut, pcOut, instructionOut, word(32'd8));
         end
      end
      stall = 1'b0;
      #1;
      total++; if (imemReqValid !== 1'b0) begin bad++; $display("FAIL stall_nocredit got=%h want=0", imemReqValid); end
      for (int j = 0; j < 6; j++) begin
         cycle();
         total++; if (validOut !== 1'b1 || pcOut !== 32'(16 + 4*j) || instructionOut !== word(32'(12 + 4*j))) begin
            bad++; $display("FAIL stall_resume%0d got=%h/%h/%h want=1/%h/%h", j, validOut, pcOut, instructionOut, 32'(16 + 4*j), word(32'(12 + 4*j)));
         end
      end
   endtask

   task automatic test_branch();
      logic found;
      do_reset(2);
      cycle();
      cycle();
      branchTaken = 1'b1; branchTarget = 32'h103;
      #1;
      total++; if (imemReqValid !== 1'b0) begin bad++; $display("FAIL br_req got=%h want=0", imemReqValid); end
      cycle();
      branchTaken = 1'b0;
      #1;
      total++; if (imemAddr !== 32'h100) begin bad++; $display("FAIL br_addr got=%h want=00000100", imemAddr); end
      total++; if (validOut !== 1'b0) begin bad++; $display("FAIL br_bubble got=%h want=0", validOut); end
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle();
         if (validOut) found = 1'b1;
      end
      total++; if (!found) begin bad++; $display("FAIL br_timeout got=0 want=1"); end
      else if (pcOut !== 32'h104 || instructionOut !== word(32'h100)) begin
         bad++; $display("FAIL br_first got=%h/%h want=00000104/%h", pcOut, instructionOut, word(32'h100));
      end
      cycle();
      total++; if (validOut !== 1'b1 || pcOut !== 32'h108 || instructionOut !== word(32'h104)) begin
         bad++; $display("FAIL br_second got=%h/%h/%h want=1/00000108/%h", validOut, pcOut, instructionOut, word(32'h104));
      end
   endtask

   task automatic test_branch_stall();
      logic found;
      do_reset(1);
      repeat (4) cycle();
      stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h200;
      cycle();
      total++; if (validOut !== 1'b0 || instructionOut !== 32'h0) begin
         bad++; $display("FAIL brst_bubble got=%h/%h want=0/00000000", validOut, instructionOut);
      end
      total++; if (imemAddr !== 32'h200) begin bad++; $display("FAIL brst_addr got=%h want=00000200", imemAddr); end
      stall = 1'b0; branchTaken = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle();
         if (validOut) found = 1'b1;
      end
      total++; if (!found) begin bad++; $display("FAIL brst_timeout got=0 want=1"); end
      else if (pcOut !== 32'h204 || instructionOut !== word(32'h200)) begin
         bad++; $display("FAIL brst_first got=%h/%h want=00000204/%h", pcOut, instructionOut, word(32'h200));
      end
   endtask

   task automatic test_ready();
      logic [31:0] exp;
      do_reset(1);
      repeat (4) cycle();
      imemReady = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         total++; if (imemAddr !== 32'd16 || imemReqValid !== 1'b1) begin
            bad++; $display("FAIL rdy_hold%0d got=%h/%h want=00000010/1", i, imemAddr, imemReqValid);
         end
         cycle();
      end
      imemReady = 1'b1;
      exp = 32'd20;
      for (int i = 0; i < 20 && exp != 32'd32; i++) begin
         cycle();
         if (validOut) begin
            total++; if (pcOut !== exp || instructionOut !== word(exp - 32'd4)) begin
               bad++; $display("FAIL rdy_seq got=%h/%h want=%h/%h", pcOut, instructionOut, exp, word(exp - 32'd4));
            end
            exp = exp + 32'd4;
         end
      end
      total++; if (exp !== 32'd32) begin bad++; $display("FAIL rdy_timeout got=%h want=00000020", exp); end
   endtask

   task automatic test_reset_mid();
      logic found;
      do_reset(1);
      repeat (5) cycle();
      stall = 1'b1;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      total++; if (validOut !== 1'b0 || pcOut !== 32'h0 || instructionOut !== 32'h0 || imemReqValid !== 1'b0) begin
         bad++; $display("FAIL rmid_state got=%h/%h/%h/%h want=0/0/0/0", validOut, pcOut, instructionOut, imemReqValid);
      end
      rst = 1'b0; stall = 1'b0;
      #1;
      total++; if (imemAddr !== 32'h0 || imemReqValid !== 1'b1) begin
         bad++; $display("FAIL rmid_addr got=%h/%h want=00000000/1", imemAddr, imemReqValid);
      end
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle();
         if (validOut) found = 1'b1;
      end
      total++; if (!found) begin bad++; $display("FAIL rmid_timeout got=0 want=1"); end
      else if (pcOut !== 32'h4 || instructionOut !== word(32'h0)) begin
         bad++; $display("FAIL rmid_first got=%h/%h want=00000004/%h", pcOut, instructionOut, word(32'h0));
      end
      cycle();
      total++; if (validOut !== 1'b1 || pcOut !== 32'h8) begin
         bad++; $display("FAIL rmid_second got=%h/%h want=1/00000008", validOut, pcOut);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
      imemReady = 1'b1; imemRespValid = 1'b0; imemRespData = '0;
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_branch_stall();
      test_ready();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
